id_exe_reg: RTL
===============

# id_exe_reg

Pipeline register between the instruction-decode stage (register file, control unit, hazard logic) and the execute stage of the 5-stage ARM-subset core. It captures the control-unit outputs (exe_cmd, mem_r_en, mem_w_en, wb_en, s, b) and the decoded operands on each clock edge. It inserts bubbles on branch flush and holds state on hazard freeze. It also keeps saturating stall and flush event counters for the debug port.

## Interface
- `CNT_W`, default 16: width of each event counter.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: branch taken in EXE; the incoming ID contents are squashed.
- `freeze` in 1: hazard detected; hold all stored values.
- `id_exe_cmd` in 4: ALU command from the control unit.
- `id_mem_r_en`, `id_mem_w_en`, `id_wb_en`, `id_s`, `id_b` in 1 each: control bits.
- `id_pc` in 32: PC+4 of the instruction.
- `id_val_rn`, `id_val_rm` in 32 each: register-file read data.
- `id_imm` in 1: I bit of the instruction.
- `id_shift_operand` in 12: shifter operand field.
- `id_signed_imm_24` in 24: branch offset.
- `id_dest` in 4: destination register.
- `id_src1`, `id_src2` in 4 each: source registers, forwarded to the forwarding unit.
- `id_status` in 4: NZCV flags sampled in ID.
- `exe_*` out: registered copies of every `id_*` input, same widths.
- `exe_valid` out 1: the EXE slot holds a real instruction.
- `stall_cnt` out `CNT_W`: cycles in which freeze held the register.
- `flush_cnt` out `CNT_W`: cycles in which flush inserted a bubble.

## Operation
- Per-cycle priority is flush > freeze > load.
- Flush:
  - Clears every control output: `exe_wb_en`, `exe_mem_r_en`, `exe_mem_w_en`, `exe_s`, `exe_b` = 0, `exe_exe_cmd` = 4'b0000, `exe_valid` = 0.
  - Datapath fields are loaded from `id_*` anyway; they are don't-care when `exe_valid` = 0.
- Freeze with no flush: all outputs keep their values, including `exe_valid`.
- Load:
  - All `exe_*` outputs take `id_*`.
  - `exe_valid` = 1.
  - The block never loads `x` from a branch-mode `id_exe_cmd`. It substitutes 4'b0000 whenever `id_b` = 1.
- Counters:
  - `stall_cnt` increments when freeze = 1 and flush = 0.
  - `flush_cnt` increments when flush = 1, regardless of freeze.
  - Both saturate at all-ones and never wrap.
- Simultaneous flush and freeze: the flush takes effect and only `flush_cnt` increments.
- Reset:
  - All outputs and counters are 0, and `exe_valid` = 0.
  - Reset asserted mid-operation clears state immediately and asynchronously, independent of `clk`.
  - The first load takes place on the first rising edge after `rst_n` deasserts.

## Timing
- Latency is one cycle: `id_*` sampled at edge N appears on `exe_*` after edge N.
- No combinational path from input to output. All outputs come directly from flops.
- `flush` and `freeze` are sampled on the same edge as the data.
- A freeze lasting k cycles holds the outputs for k edges and adds k to `stall_cnt`, up to saturation.
- Back-to-back flushes produce consecutive bubbles.
- Saturation: once a counter equals 2^CNT_W−1, further events leave it unchanged.

## Structure
- Shared core package holds:
  - the exe_cmd constants (MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, NOP 0000);
  - the mode encodings (00 data-processing, 01 memory, 10 branch);
  - the NZCV bit indices.
- One sub-module, `sat_counter` (parameter `CNT_W`, inputs `inc`, `clk`, `rst_n`), instantiated twice.
- The pipeline-register body stays inline.

## Test plan
- **Reset mid-stream:** load ADD (exe_cmd 0010, wb_en 1); assert `rst_n` = 0 between edges. All outputs and counters must read 0 before the next edge.
- **Plain load:** id_exe_cmd 0010, wb_en 1, val_rn 5, val_rm 7, dest 3. One edge later `exe_*` matches the inputs and `exe_valid` = 1.
- **Freeze for 3 cycles:** freeze = 1 while the inputs change to SUB. Outputs keep the ADD values for 3 edges and `stall_cnt` = 3.
- **Flush while frozen:** flush = 1 and freeze = 1 with a STR (mem_w_en 1) on input. Next cycle mem_w_en = 0, `exe_valid` = 0, `flush_cnt` = 1, `stall_cnt` unchanged.
- **Branch input:** id_b = 1 with id_exe_cmd = x. Result is exe_b = 1, exe_exe_cmd = 0000, and exe_signed_imm_24 = 24'hFFFFFE carried through.
- **Saturation:** with CNT_W = 4, hold freeze for 20 cycles. `stall_cnt` stops at 15 and does not wrap.

Source files
------------

// File: rtl/id_exe_reg_pkg.sv
// ============================================================================
// Module : id_exe_reg_pkg
// Shared core constants (ALU commands, modes, NZCV) and the ID/EXE payload.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package id_exe_reg_pkg;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam int STATUS_N = 3;
    localparam int STATUS_Z = 2;
    localparam int STATUS_C = 1;
    localparam int STATUS_V = 0;

    typedef struct packed {
        logic [3:0]  exe_cmd;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
        logic        s;
        logic        b;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  status;
    } id_exe_bus_t;

    // Branches carry no meaningful ALU command; force NOP so EXE never sees junk.
    function automatic logic [3:0] sanitize_cmd(input logic b, input logic [3:0] cmd);
        return b ? EXE_NOP : cmd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_exe_reg_sat_counter.sv
// ============================================================================
// Module : sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/id_exe_reg.sv
// ============================================================================
// Module : id_exe_reg
// ID->EXE pipeline register with flush bubbles, freeze hold and event counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_exe_reg
    import id_exe_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             freeze,
    input  logic [3:0]       id_exe_cmd,
    input  logic             id_mem_r_en,
    input  logic             id_mem_w_en,
    input  logic             id_wb_en,
    input  logic             id_s,
    input  logic             id_b,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_val_rn,
    input  logic [31:0]      id_val_rm,
    input  logic             id_imm,
    input  logic [11:0]      id_shift_operand,
    input  logic [23:0]      id_signed_imm_24,
    input  logic [3:0]       id_dest,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic [3:0]       id_status,
    output logic [3:0]       exe_exe_cmd,
    output logic             exe_mem_r_en,
    output logic             exe_mem_w_en,
    output logic             exe_wb_en,
    output logic             exe_s,
    output logic             exe_b,
    output logic [31:0]      exe_pc,
    output logic [31:0]      exe_val_rn,
    output logic [31:0]      exe_val_rm,
    output logic             exe_imm,
    output logic [11:0]      exe_shift_operand,
    output logic [23:0]      exe_signed_imm_24,
    output logic [3:0]       exe_dest,
    output logic [3:0]       exe_src1,
    output logic [3:0]       exe_src2,
    output logic [3:0]       exe_status,
    output logic             exe_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    id_exe_bus_t in_bus;
    id_exe_bus_t bus_d;
    id_exe_bus_t bus_q;
    logic        valid_d;
    logic        valid_q;

    assign in_bus = '{
        exe_cmd:       id_exe_cmd,
        mem_r_en:      id_mem_r_en,
        mem_w_en:      id_mem_w_en,
        wb_en:         id_wb_en,
        s:             id_s,
        b:             id_b,
        pc:            id_pc,
        val_rn:        id_val_rn,
        val_rm:        id_val_rm,
        imm:           id_imm,
        shift_operand: id_shift_operand,
        signed_imm_24: id_signed_imm_24,
        dest:          id_dest,
        src1:          id_src1,
        src2:          id_src2,
        status:        id_status
    };

    // Flush beats freeze: a bubble still loads datapath fields, only control is zeroed.
    always_comb begin
        bus_d   = bus_q;
        valid_d = valid_q;
        if (flush) begin
            bus_d          = in_bus;
            bus_d.exe_cmd  = EXE_NOP;
            bus_d.mem_r_en = 1'b0;
            bus_d.mem_w_en = 1'b0;
            bus_d.wb_en    = 1'b0;
            bus_d.s        = 1'b0;
            bus_d.b        = 1'b0;
            valid_d        = 1'b0;
        end else if (!freeze) begin
            bus_d         = in_bus;
            bus_d.exe_cmd = sanitize_cmd(id_b, id_exe_cmd);
            valid_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            bus_q   <= bus_d;
            valid_q <= valid_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (freeze & ~flush),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .cnt   (flush_cnt)
    );

    assign exe_exe_cmd       = bus_q.exe_cmd;
    assign exe_mem_r_en      = bus_q.mem_r_en;
    assign exe_mem_w_en      = bus_q.mem_w_en;
    assign exe_wb_en         = bus_q.wb_en;
    assign exe_s             = bus_q.s;
    assign exe_b             = bus_q.b;
    assign exe_pc            = bus_q.pc;
    assign exe_val_rn        = bus_q.val_rn;
    assign exe_val_rm        = bus_q.val_rm;
    assign exe_imm           = bus_q.imm;
    assign exe_shift_operand = bus_q.shift_operand;
    assign exe_signed_imm_24 = bus_q.signed_imm_24;
    assign exe_dest          = bus_q.dest;
    assign exe_src1          = bus_q.src1;
    assign exe_src2          = bus_q.src2;
    assign exe_status        = bus_q.status;
    assign exe_valid         = valid_q;

endmodule

`default_nettype wire
